// File: rtl/disp_share_ctrl_pkg.sv
// Shared constants for the shared 7-segment display controller:
// segment encodings, arbiter state encoding and default timing.
package disp_share_ctrl_pkg;

  localparam int DEF_SCAN_DIV    = 65536;
  localparam int DEF_DWELL_SLOTS = 4096;

  // Segment order {a,b,c,d,e,f,g}, active-high
  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h1F;
  localparam logic [6:0] SEG_C     = 7'h4E;
  localparam logic [6:0] SEG_D     = 7'h3D;
  localparam logic [6:0] SEG_E     = 7'h4F;
  localparam logic [6:0] SEG_F     = 7'h47;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_t;

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      default: s = SEG_F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/disp_scan_timer.sv
// Digit scan timing: divides clk into digit slots, pulses slot_tick on each
// slot boundary and rotates the one-hot digit enable.
module disp_scan_timer
  import disp_share_ctrl_pkg::*;
#(
  parameter int SCAN_DIV = DEF_SCAN_DIV
) (
  input  logic       clk,
  input  logic       rst,
  output logic       slot_tick,
  output logic [1:0] idx,
  output logic [3:0] segen
);

  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0] cnt;

  assign slot_tick = (cnt == CW'(SCAN_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      idx   <= 2'd0;
      segen <= 4'b0001;
    end else if (slot_tick) begin
      cnt   <= '0;
      idx   <= idx + 2'd1;
      segen <= {segen[2:0], segen[3]};
    end else begin
      cnt   <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/disp_share_ctrl.sv
// Round-robin time-sharing of one 4-digit 7-segment display between N_REQ
// 16-bit sources, with dwell-timed grants and tear-free frame updates.
module disp_share_ctrl
  import disp_share_ctrl_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int SCAN_DIV    = DEF_SCAN_DIV,
  parameter int DWELL_SLOTS = DEF_DWELL_SLOTS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [16*N_REQ-1:0]  data,
  output logic [6:0]           seg,
  output logic [3:0]           segen,
  output logic [N_REQ-1:0]     grant,
  output logic                 busy
);

  localparam int IW = $clog2(N_REQ);
  localparam int DW = $clog2(DWELL_SLOTS);

  logic             slot_tick;
  logic [1:0]       idx;
  arb_state_t       state;
  logic [IW-1:0]    owner;
  logic [IW-1:0]    ptr;
  logic [DW-1:0]    dwell;
  logic [15:0]      shadow;
  logic             found;
  logic [IW-1:0]    pick;
  logic [IW-1:0]    cand;
  logic [N_REQ-1:0] pick_onehot;
  logic             rearb;
  logic             frame_tick;

  disp_scan_timer #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk       (clk),
    .rst       (rst),
    .slot_tick (slot_tick),
    .idx       (idx),
    .segen     (segen)
  );

  // Search runs downward so the lowest offset from ptr wins; ptr itself is last.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = IW'((int'(ptr) + k) % N_REQ);
      if (req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    pick_onehot       = '0;
    pick_onehot[pick] = 1'b1;
  end

  assign rearb      = (state == ST_IDLE) || !req[owner] ||
                      (dwell == DW'(DWELL_SLOTS - 1));
  assign frame_tick = slot_tick && (idx == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      owner  <= '0;
      ptr    <= IW'(N_REQ - 1);
      dwell  <= '0;
      shadow <= '0;
      grant  <= '0;
      busy   <= 1'b0;
    end else if (slot_tick) begin
      if (rearb) begin
        dwell <= '0;
        if (found) begin
          state  <= ST_HOLD;
          owner  <= pick;
          ptr    <= pick;
          shadow <= data[16*pick +: 16];
          grant  <= pick_onehot;
          busy   <= 1'b1;
        end else begin
          state <= ST_IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      end else begin
        dwell <= dwell + DW'(1);
        // Reload only at the frame boundary so a frame never mixes two values
        if (frame_tick) shadow <= data[16*owner +: 16];
      end
    end
  end

  // Segment stage: one clock behind index/shadow/grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= SEG_BLANK;
    end else begin
      seg <= (grant == '0) ? SEG_BLANK : hex7(shadow[4*idx +: 4]);
    end
  end

endmodule
